// File: rtl/rv32_alu_pkg.sv
// Shared ALU types: operation encodings and a mnemonic helper for reporting.
package alu_types;

  typedef enum logic [3:0] {
    ALU_INVALID = 4'b0000,
    ALU_AND     = 4'b0001,
    ALU_OR      = 4'b0010,
    ALU_XOR     = 4'b0011,
    ALU_SLL     = 4'b0101,
    ALU_SRL     = 4'b0110,
    ALU_SRA     = 4'b0111,
    ALU_ADD     = 4'b1000,
    ALU_SUB     = 4'b1100,
    ALU_SLT     = 4'b1101,
    ALU_SLTU    = 4'b1111
  } alu_control_t;

  function automatic string alu_control_name(alu_control_t c);
    case (c)
      ALU_INVALID: return "INVALID";
      ALU_AND:     return "AND";
      ALU_OR:      return "OR";
      ALU_XOR:     return "XOR";
      ALU_SLL:     return "SLL";
      ALU_SRL:     return "SRL";
      ALU_SRA:     return "SRA";
      ALU_ADD:     return "ADD";
      ALU_SUB:     return "SUB";
      ALU_SLT:     return "SLT";
      ALU_SLTU:    return "SLTU";
      default:     return "UNLISTED";
    endcase
  endfunction

endpackage

// File: rtl/rv32_alu_if.sv
// Operand/control and registered result bundle between the operand muxes and the ALU.
interface rv32_alu_if
  import alu_types::*;
#(
  parameter int N = 32
);
  logic [N-1:0] a;
  logic [N-1:0] b;
  alu_control_t control;
  logic [N-1:0] result;
  logic         overflow;
  logic         zero;
  logic         equal;

  modport master (
    output a, b, control,
    input  result, overflow, zero, equal
  );

  modport slave (
    input  a, b, control,
    output result, overflow, zero, equal
  );
endinterface

// File: rtl/rv32_alu_adder_subtractor.sv
// N-bit adder/subtractor; subtraction is a + ~b + 1 so carry_out doubles as "no borrow".
module adder_subtractor #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         carry_out,
  output logic         overflow
);
  logic [N-1:0] b_eff;

  assign b_eff = sub ? ~b : b;
  assign {carry_out, sum} = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sub};
  // Operands agreeing in sign (after inversion) but a result of the other sign.
  assign overflow = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);
endmodule

// File: rtl/rv32_alu.sv
// Registered RV32I ALU: logic, shift, add/sub and set-less-than with overflow/zero/equal flags.
module rv32_alu
  import alu_types::*;
#(
  parameter int N = 32
) (
  input logic        clk,
  input logic        rst,
  rv32_alu_if.slave  bus
);
  logic [N-1:0] sum;
  logic         carry_out;
  logic         add_ovf;
  logic         is_sub;
  logic [4:0]   shamt;

  logic [N-1:0] result_d, result_q;
  logic         overflow_d, overflow_q;
  logic         zero_d, zero_q;
  logic         equal_d, equal_q;

  assign is_sub = (bus.control == ALU_SUB) || (bus.control == ALU_SLT) ||
                  (bus.control == ALU_SLTU);
  assign shamt  = bus.b[4:0];

  adder_subtractor #(.N(N)) u_addsub (
    .a         (bus.a),
    .b         (bus.b),
    .sub       (is_sub),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (add_ovf)
  );

  always_comb begin
    result_d   = '0;
    overflow_d = 1'b0;
    case (bus.control)
      ALU_AND: result_d = bus.a & bus.b;
      ALU_OR:  result_d = bus.a | bus.b;
      ALU_XOR: result_d = bus.a ^ bus.b;
      ALU_SLL: result_d = bus.a << shamt;
      ALU_SRL: result_d = bus.a >> shamt;
      ALU_SRA: result_d = N'($signed(bus.a) >>> shamt);
      ALU_ADD: begin
        result_d   = sum;
        overflow_d = add_ovf;
      end
      ALU_SUB: begin
        result_d   = sum;
        overflow_d = add_ovf;
      end
      // Sign of the difference is wrong exactly when the subtraction overflowed.
      ALU_SLT:  result_d = {{(N-1){1'b0}}, sum[N-1] ^ add_ovf};
      ALU_SLTU: result_d = {{(N-1){1'b0}}, ~carry_out};
      default: begin
        result_d   = '0;
        overflow_d = 1'b0;
      end
    endcase
    zero_d  = (result_d == '0);
    equal_d = (bus.a == bus.b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b1;
      equal_q    <= 1'b0;
    end else begin
      result_q   <= result_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      equal_q    <= equal_d;
    end
  end

  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;
  assign bus.zero     = zero_q;
  assign bus.equal    = equal_q;
endmodule

// File: tb/tb_rv32_alu.sv
// Scoreboard bench: driver queues expected responses, monitor checks them one cycle later.
module tb_rv32_alu;
  import alu_types::*;

  typedef struct {
    logic [31:0] result;
    logic        ovf;
    logic        zero;
    logic        eq;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic issue = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t scb[$];

  rv32_alu_if #(.N(32)) bus ();

  rv32_alu #(.N(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Independent reference: wide signed arithmetic for add/sub, sign-extended word for SRA.
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, w;
    logic [63:0] ext;
    logic [63:0] sh_res;
    int     sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    e.result = 32'h0;
    e.ovf    = 1'b0;
    case (c)
      4'b0001: e.result = a & b;
      4'b0010: e.result = a | b;
      4'b0011: e.result = a ^ b;
      4'b0101: e.result = a << sh;
      4'b0110: e.result = a >> sh;
      4'b0111: begin
        ext      = {{32{a[31]}}, a};
        sh_res   = ext >> sh;
        e.result = sh_res[31:0];
      end
      4'b1000, 4'b1100: begin
        w        = (c == 4'b1000) ? sa + sb : sa - sb;
        e.result = w[31:0];
        e.ovf    = (w > 64'sd2147483647) || (w < -64'sd2147483648);
      end
      4'b1101: e.result = (sa < sb) ? 32'd1 : 32'd0;
      4'b1111: e.result = (a < b) ? 32'd1 : 32'd0;
      default: e.result = 32'h0;
    endcase
    e.zero = (e.result == 32'h0);
    e.eq   = (a == b);
    e.tag  = "";
    return e;
  endfunction

  task automatic send(input logic r, input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] b, input exp_t e);
    exp_t ee;
    @(negedge clk);
    rst         = r;
    bus.control = alu_control_t'(c);
    bus.a       = a;
    bus.b       = b;
    issue       = 1'b1;
    ee          = e;
    ee.tag      = $sformatf("%s%s a=%h b=%h", r ? "RST+" : "",
                            alu_control_name(alu_control_t'(c)), a, b);
    scb.push_back(ee);
  endtask

  task automatic dir(input logic r, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic ovf, input logic z, input logic eq);
    exp_t e;
    e.result = res;
    e.ovf    = ovf;
    e.zero   = z;
    e.eq     = eq;
    e.tag    = "";
    send(r, c, a, b, e);
  endtask

  // Monitor: an operand set issued before this edge shows up just after it.
  initial begin
    logic t;
    exp_t e;
    forever begin
      @(posedge clk);
      t = issue;
      #1;
      if (t) begin
        checks++;
        if (scb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty result=%h", bus.result);
        end else begin
          e = scb.pop_front();
          if (bus.result !== e.result || bus.overflow !== e.ovf ||
              bus.zero !== e.zero || bus.equal !== e.eq) begin
            errors++;
            $display("FAIL %s got res=%h ovf=%b z=%b eq=%b expected res=%h ovf=%b z=%b eq=%b",
                     e.tag, bus.result, bus.overflow, bus.zero, bus.equal,
                     e.result, e.ovf, e.zero, e.eq);
          end else begin
            $display("ok   %s res=%h ovf=%b z=%b eq=%b", e.tag, bus.result,
                     bus.overflow, bus.zero, bus.equal);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] corners [7];
    logic [3:0]  ops [11];
    logic [31:0] ra, rb;
    corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'hAAAAAAAA, 32'h55555555};
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110, 4'b0111,
            4'b1000, 4'b1100, 4'b1101, 4'b1111};
    bus.a       = '0;
    bus.b       = '0;
    bus.control = ALU_INVALID;
    repeat (2) @(negedge clk);

    // Reset state, then reset dominating a pending ADD.
    dir(1'b1, 4'b1000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    dir(1'b1, 4'b1000, 32'h1, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0);
    dir(1'b0, 4'b0000, 32'h5, 32'h5, 32'h0, 1'b0, 1'b1, 1'b1);

    dir(1'b0, 4'b1000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0);
    dir(1'b0, 4'b1100, 32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1'b1, 1'b1);
    dir(1'b0, 4'b1101, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0);
    dir(1'b0, 4'b1111, 32'h80000000, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0);
    dir(1'b0, 4'b1101, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0);
    dir(1'b0, 4'b1111, 32'h00000001, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 1'b0);
    dir(1'b0, 4'b0111, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b0, 1'b0);
    dir(1'b0, 4'b0110, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1'b0, 1'b0);
    dir(1'b0, 4'b0101, 32'h80000000, 32'h00000024, 32'h00000000, 1'b0, 1'b1, 1'b0);
    dir(1'b0, 4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0);
    dir(1'b0, 4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);
    dir(1'b0, 4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0);
    dir(1'b0, 4'b1100, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0);
    dir(1'b0, 4'b1100, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    dir(1'b0, 4'b1000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0);
    dir(1'b0, 4'b0100, 32'h00000003, 32'h00000003, 32'h00000000, 1'b0, 1'b1, 1'b1);
    dir(1'b0, 4'b1110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0);
    // Mid-stream reset discards the in-flight ADD, then normal flow resumes.
    dir(1'b0, 4'b1000, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 1'b0);
    dir(1'b1, 4'b1000, 32'h00000002, 32'h00000002, 32'h00000000, 1'b0, 1'b1, 1'b0);
    dir(1'b0, 4'b1000, 32'h00000002, 32'h00000002, 32'h00000004, 1'b0, 1'b0, 1'b1);

    foreach (ops[oi])
      foreach (corners[ai])
        foreach (corners[bi])
          send(1'b0, ops[oi], corners[ai], corners[bi], model(ops[oi], corners[ai], corners[bi]));

    for (int k = 0; k < 60; k++) begin
      ra = $urandom;
      rb = $urandom;
      send(1'b0, ops[k % 11], ra, rb, model(ops[k % 11], ra, rb));
    end

    @(negedge clk);
    issue = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (scb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected=0", scb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32_alu.md
# rv32_alu

Registered 32-bit integer ALU for the RV32I datapath: computes logic, shift, add/subtract and set-less-than results from two operands under a 4-bit control code. It also produces overflow, zero and equal flags. It sits between the register-file/immediate muxes and the writeback/branch logic. All outputs are registered, so the execute stage sees results one cycle after operands are presented.

## Interface
- `N`, default 32: operand width. Only 32 is supported; other values are out of scope.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a`  in  N  operand A.
- `b`  in  N  operand B; bits [4:0] are the shift amount for shifts.
- `control`  in  4 (`alu_control_t`)  operation select.
- `result`  out  N  registered operation result.
- `overflow`  out  1  registered signed overflow; meaningful for ADD/SUB only.
- `zero`  out  1  registered; high when `result` is all zeros.
- `equal`  out  1  registered; high when `a == b` in the sampled cycle.

## Operation
Control encodings (`alu_control_t`):
- INVALID=0000, AND=0001, OR=0010, XOR=0011.
- SLL=0101, SRL=0110, SRA=0111.
- ADD=1000, SUB=1100, SLT=1101, SLTU=1111.

Results:
- AND/OR/XOR: bitwise.
- SLL/SRL: logical shift of `a` by `b[4:0]`; `b[31:5]` is ignored.
- SRA: arithmetic shift of `a` by `b[4:0]`, sign-filled.
- ADD: `a+b` mod 2^32. SUB: `a-b` mod 2^32, implemented as `a + ~b + 1`.
- SLT: 1 if `$signed(a) < $signed(b)`, else 0, zero-extended.
  - Must be correct even when `a-b` overflows, i.e. use sign of difference XOR overflow.
- SLTU: 1 if `a < b` unsigned (carry-out of `a + ~b + 1` is 0), else 0.
- INVALID and any unlisted code: `result=0`, `overflow=0`.

Flags:
- `overflow`, ADD: `a[31]==b[31]` and `sum[31]!=a[31]`.
- `overflow`, SUB: `a[31]!=b[31]` and `diff[31]!=a[31]`.
- `overflow` is 0 for every other op, including SLT/SLTU.
- `zero` = (next result == 0), for every op including INVALID (so INVALID gives `zero=1`).
- `equal` = (`a == b`), independent of `control`.

## Timing
- Combinational next-state from `a`, `b`, `control`; all four outputs update together on the rising `clk` edge.
- Latency is exactly 1 cycle; a new operation can be issued every cycle, no handshake.
- Reset (`rst` high at a rising edge):
  - `result=0`, `zero=1` (consistent with result), `overflow=0`, `equal=0`.
  - Reset dominates any operation presented in the same cycle.
  - Mid-stream reset discards the in-flight result.
- After reset deasserts, the first valid output appears one edge after operands are sampled with `rst` low.
- Outputs hold their value while inputs are stable; no X-propagation from INVALID codes.

## Structure
- Shared package `alu_types` holds:
  - `alu_control_t` (4-bit enum, encodings above).
  - `alu_control_name()`, which returns the mnemonic string for displays and test reporting.
- One sub-module, `adder_subtractor` (N-bit):
  - Inputs `a`, `b`, `sub`; outputs `sum`, `carry_out`, `overflow`.
  - Shared by ADD, SUB, SLT and SLTU.
- Shifter, logic ops, result mux and output register stay in the top level.

## Test plan
- ADD overflow: `a=7FFFFFFF`, `b=00000001`, ADD -> next cycle `result=80000000`, `overflow=1`, `zero=0`.
- SUB to zero: `a=b=12345678`, SUB -> `result=0`, `zero=1`, `equal=1`, `overflow=0`.
- SLT vs SLTU: `a=80000000`, `b=00000001`.
  - SLT -> `result=1`.
  - SLTU -> `result=0`.
  - SLT with `a=7FFFFFFF`, `b=FFFFFFFF` -> `result=0` (overflowing difference).
- Shifts with `a=80000000`, `b=00000024` (`b[4:0]`=4):
  - SRA -> `F8000000`.
  - SRL -> `08000000`.
  - SLL -> `0`, `zero=1`.
- Reset and INVALID:
  - Assert `rst` with ADD `a=1`, `b=1` pending -> `result=0`, `zero=1`, `equal=0`, `overflow=0`.
  - Release `rst`, INVALID with `a=b=5` -> `result=0`, `zero=1`, `equal=1`.
- Sweep: every op over a corner set (0, 1, FFFFFFFF, 7FFFFFFF, 80000000, alternating patterns) plus random vectors, compared cycle-delayed against a behavioural model; zero mismatches.
